// File: rtl/rv_pkg.sv
// rv core shared definitions used by the data-memory responder.
// Holds bus width, responder FSM states and error-code encoding.
package rv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam logic DMEM_ERR_NONE              = 1'b0;
  localparam logic DMEM_ERR_MISALIGN_OR_RANGE = 1'b1;

  // Flags a word access that is misaligned or beyond the RAM window.
  function automatic logic dmem_addr_bad(
    input logic [XLEN-1:0] a,
    input int unsigned     aw
  );
    logic [XLEN-1:0] hi;
    hi = a >> aw;
    return (a[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/rv_dmem_ram.sv
// Single-port word RAM with per-byte write enable.
// Read data is registered and holds until the next read.
module rv_dmem_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  // Byte-lane write or registered read, only when enabled.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (be_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rv_dmem_resp.sv
// Data-memory responder for the rv load/store port.
// One outstanding request, WAIT wait states, commit on entry to RESP.
module rv_dmem_resp #(
  parameter int ADDR_W = 12,
  parameter int WAIT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  import rv_pkg::*;

  localparam int WW = ADDR_W - 2;

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic        err_q, err_d;
  logic        rd_ok_q, rd_ok_d;

  logic        commit;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_be;
  logic        c_bad;
  logic [31:0] ram_rdata;

  // With WAIT=0 the commit happens in the accept cycle, so use live inputs.
  always_comb begin
    c_we    = we_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_be    = be_q;
    if (state_q == IDLE) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_be    = req_be;
    end
  end

  assign c_bad = dmem_addr_bad(c_addr, ADDR_W);

  // Next state, wait countdown and commit strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (WAIT == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = rv_pkg::WAIT;
            cnt_d   = 4'(WAIT - 1);
          end
        end
      end
      rv_pkg::WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Response flags are set at commit and cleared by the response handshake.
  always_comb begin
    err_d   = err_q;
    rd_ok_d = rd_ok_q;
    if (commit) begin
      err_d   = c_bad ? DMEM_ERR_MISALIGN_OR_RANGE : DMEM_ERR_NONE;
      rd_ok_d = !c_we && !c_bad;
    end else if (state_q == RESP && rsp_ready) begin
      err_d   = DMEM_ERR_NONE;
      rd_ok_d = 1'b0;
    end
  end

  // FSM, counter and response-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  // Capture the request on the accept handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (state_q == IDLE && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  rv_dmem_ram #(
    .AW (WW)
  ) u_ram (
    .clk     (clk),
    .en_i    (commit && !c_bad),
    .we_i    (c_we),
    .be_i    (c_be),
    .addr_i  (c_addr[ADDR_W-1:2]),
    .wdata_i (c_wdata),
    .rdata_o (ram_rdata)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;
  assign rsp_rdata = rd_ok_q ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_rv_dmem_resp.sv
// Bench for rv_dmem_resp: vector table, corner sequences, random vs model.
// Three instances cover WAIT=1, WAIT=0 and WAIT=3.
module tb_rv_dmem_resp;

  logic        clk;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rv_dmem_resp #(.ADDR_W(12), .WAIT(1)) u_w1 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  rv_dmem_resp #(.ADDR_W(12), .WAIT(0)) u_w0 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  rv_dmem_resp #(.ADDR_W(12), .WAIT(3)) u_w3 (
    .clk(clk), .rst_n(rst_n[2]),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]),
    .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t        tbl [12];
  logic [31:0] mdl [16];
  logic [31:0] sdat [8];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic txn(input int k, input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     output logic [31:0] rd, output logic er,
                     output int lat);
    int n;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    req_be[k]    = be;
    rsp_ready[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[k] && lat < 100);
    rd = rsp_rdata[k];
    er = rsp_err[k];
    @(posedge clk);
    #1;
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd4096);
  endfunction

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k]     = 1'b0;
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      req_be[k]    = '0;
      rsp_ready[k] = 1'b0;
    end

    tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h20,       32'h11223344, 4'hF, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[5]  = '{1'b1, 32'h0,        32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    tbl[6]  = '{1'b0, 32'h22,       32'h0,        4'h0, 32'h0,        1'b1};
    tbl[7]  = '{1'b1, 32'h1000,     32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    tbl[8]  = '{1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    tbl[9]  = '{1'b1, 32'h10,       32'h12345678, 4'h0, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[11] = '{1'b0, 32'h80000010, 32'h0,        4'h0, 32'h0,        1'b1};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[k], 32'd0);
      chk("rst_rsp_err",   32'(rsp_err[k]), 32'd0);
    end

    // vector table on WAIT=1
    for (int i = 0; i < 12; i++) begin
      txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].err));
      chk($sformatf("vec%0d_lat", i), lat, 32'd2);
    end

    // response backpressure with a pending request
    begin
      int n;
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_addr[0]  = 32'h10;
      rsp_ready[0] = 1'b0;
      @(posedge clk);
      #1 req_addr[0] = 32'h20;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rsp_valid[0] && n < 100);
      chk("bp_first", rsp_rdata[0], 32'hDEADBEEF);
      repeat (5) begin
        @(negedge clk);
        chk("bp_valid", 32'(rsp_valid[0]), 32'd1);
        chk("bp_stable", rsp_rdata[0], 32'hDEADBEEF);
        chk("bp_req_ready", 32'(req_ready[0]), 32'd0);
      end
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      chk("bp_hs_valid", 32'(rsp_valid[0]), 32'd0);
      chk("bp_hs_ready", 32'(req_ready[0]), 32'd1);
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      @(negedge clk);
      chk("bp_accepted", 32'(req_ready[0]), 32'd0);
      n = 0;
      while (!rsp_valid[0] && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("bp_second", rsp_rdata[0], 32'h11BB33DD);
      @(posedge clk);
      #1;
    end

    // back-to-back loads on WAIT=0
    for (int i = 0; i < 8; i++) begin
      sdat[i] = 32'hA5000000 | (32'(i) * 32'h00010203);
      txn(1, 1'b1, 32'h40 + 32'(4*i), sdat[i], 4'hF, rd, er, lat);
      chk("w0_store_lat", lat, 32'd1);
    end
    begin
      int idx, got, cyc, lastc;
      idx = 0;
      got = 0;
      cyc = 0;
      lastc = 0;
      rsp_ready[1] = 1'b1;
      while (got < 8 && cyc < 100) begin
        @(negedge clk);
        cyc++;
        if (rsp_valid[1]) begin
          chk("stream_data", rsp_rdata[1], sdat[got]);
          if (got > 0) chk("stream_gap", cyc - lastc, 32'd2);
          lastc = cyc;
          got++;
        end
        if (req_ready[1]) begin
          if (idx < 8) begin
            req_valid[1] = 1'b1;
            req_we[1]    = 1'b0;
            req_addr[1]  = 32'h40 + 32'(4*idx);
            idx++;
          end else begin
            req_valid[1] = 1'b0;
          end
        end
      end
      req_valid[1] = 1'b0;
      chk("stream_count", got, 32'd8);
    end

    // reset during wait states drops the store (WAIT=3)
    txn(2, 1'b1, 32'h0, 32'h12345678, 4'hF, rd, er, lat);
    chk("w3_store_lat", lat, 32'd4);
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 32'h0;
    req_wdata[2] = 32'h00000055;
    req_be[2]    = 4'hF;
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready[2]), 32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    chk("mid_rst_rdata", rsp_rdata[2], 32'd0);
    chk("mid_rst_err", 32'(rsp_err[2]), 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    txn(2, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("mid_rst_old", rd, 32'h12345678);
    chk("mid_rst_lat", lat, 32'd4);

    // random traffic on WAIT=1 against a word model
    for (int i = 0; i < 16; i++) begin
      mdl[i] = $urandom;
      txn(0, 1'b1, 32'(4*i), mdl[i], 4'hF, rd, er, lat);
    end
    for (int t = 0; t < 60; t++) begin
      logic        we;
      logic [31:0] a, wd, erd;
      logic [3:0]  be;
      logic        eer;
      int          sel, w;
      sel = $urandom_range(0, 9);
      w   = $urandom_range(0, 15);
      if (sel <= 6)      a = 32'(4*w);
      else if (sel == 7) a = 32'(4*w + $urandom_range(1, 3));
      else if (sel == 8) a = 32'h1000 + 32'($urandom_range(0, 255) * 4);
      else               a = ($urandom | 32'h80000000) & ~32'h3;
      we  = 1'($urandom_range(0, 1));
      be  = 4'($urandom_range(0, 15));
      wd  = $urandom;
      erd = 32'h0;
      eer = addr_bad(a);
      if (!eer) begin
        if (we) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) mdl[a/4][8*b +: 8] = wd[8*b +: 8];
          end
        end else begin
          erd = mdl[a/4];
        end
      end
      txn(0, we, a, wd, be, rd, er, lat);
      chk($sformatf("rnd%0d_rdata a=%h", t, a), rd, erd);
      chk($sformatf("rnd%0d_err a=%h", t, a), 32'(er), 32'(eer));
      chk($sformatf("rnd%0d_lat", t), lat, 32'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
